// File: rtl/oam_dma_arbiter_if.sv
// Shared-bus handshake bundle between the CPU, the OAM DMA arbiter and the system bus.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic [7:0]  bus_d_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic        cpu_rdy;
  logic        dma_busy;

  modport master (
    output cpu_addr, cpu_d_out, cpu_we, bus_d_in,
    input  bus_addr, bus_d_out, bus_we, cpu_rdy, dma_busy
  );

  modport slave (
    input  cpu_addr, cpu_d_out, cpu_we, bus_d_in,
    output bus_addr, bus_d_out, bus_we, cpu_rdy, dma_busy
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA arbiter: a CPU write to DMA_REG_ADDR stalls the CPU and copies a 256-byte page into OAM.
// Define OAM_DMA_ODD_ALIGN_EN to insert one alignment cycle when the halt cycle lands on an odd cycle.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic              clk,
  input logic              rst,
  oam_dma_arbiter_if.slave arb
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  idx;
  logic [7:0]  page;
  logic [7:0]  buffer;
  logic        take_align_c;

  logic [15:0] bus_addr_c;
  logic [7:0]  bus_d_out_c;
  logic        bus_we_c;
  logic        cpu_rdy_c;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic cyc_odd;

  // Free-running cycle parity used to decide whether the transfer needs an alignment slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_odd <= 1'b0;
    else     cyc_odd <= ~cyc_odd;
  end

  assign take_align_c = cyc_odd;
`else
  assign take_align_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 8'h00;
      page   <= 8'h00;
      buffer <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (arb.cpu_we && (arb.cpu_addr == DMA_REG_ADDR)) begin
            page  <= arb.cpu_d_out;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        HALT:  state <= take_align_c ? ALIGN : READ;
        ALIGN: state <= READ;
        READ: begin
          buffer <= arb.bus_d_in;
          state  <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus steering is a pure function of state and registers; bus_d_in only reaches the buffer.
  always_comb begin
    bus_addr_c  = arb.cpu_addr;
    bus_d_out_c = 8'h00;
    bus_we_c    = 1'b0;
    cpu_rdy_c   = 1'b0;
    case (state)
      IDLE: begin
        bus_d_out_c = arb.cpu_d_out;
        bus_we_c    = arb.cpu_we;
        cpu_rdy_c   = 1'b1;
      end
      READ: bus_addr_c = {page, idx};
      WRITE: begin
        bus_addr_c  = OAM_DATA_ADDR;
        bus_d_out_c = buffer;
        bus_we_c    = 1'b1;
      end
      default: ;
    endcase
  end

  assign arb.bus_addr  = bus_addr_c;
  assign arb.bus_d_out = bus_d_out_c;
  assign arb.bus_we    = bus_we_c;
  assign arb.cpu_rdy   = cpu_rdy_c;
  assign arb.dma_busy  = ~cpu_rdy_c;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: OAM write data is scoreboarded against a memory model.
module tb_oam_dma_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oam_dma_arbiter_if bif ();

  oam_dma_arbiter dut (
    .clk (clk),
    .rst (rst),
    .arb (bif.slave)
  );

  // Page $02 holds memory[i]=i; every other page holds i ^ page so each page is distinguishable.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return (a[15:8] == 8'h02) ? a[7:0] : (a[7:0] ^ a[15:8]);
  endfunction

  assign bif.bus_d_in = mem_rd(bif.bus_addr);

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         busy_run = 0;
  int         last_busy = 0;
  int         oam_writes = 0;
  logic       tb_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard OAM writes and measure stall length.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      check("busy_is_not_rdy", 32'(bif.dma_busy), 32'(!bif.cpu_rdy));
      if (bif.bus_we && (bif.bus_addr == 16'h2004) && bif.dma_busy) begin
        oam_writes++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          assert (exp_q.size() != 0)
          else begin
            n_err++;
            $error("FAIL extra_oam_write: observed data %0h expected no write", bif.bus_d_out);
          end
        end else begin
          check("oam_data", 32'(bif.bus_d_out), 32'(exp_q.pop_front()));
        end
      end
      if (!bif.cpu_rdy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        last_busy = busy_run;
        busy_run  = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_par(input logic p);
    if (tb_par !== p) tick(1);
  endtask

  task automatic push_page(input logic [7:0] pg);
    logic [7:0] mask;
    mask = (pg == 8'h02) ? 8'h00 : pg;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ mask);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k;
    k = 0;
    while (!bif.cpu_rdy && k < limit) begin
      tick(1);
      k++;
    end
    check({tag, "_finished"}, 32'(bif.cpu_rdy), 32'd1);
  endtask

  task automatic run_dma(input logic [7:0] pg, input string tag, input bit poke);
    int exp_busy;
    exp_busy = 513;
`ifdef OAM_DMA_ODD_ALIGN_EN
    if (!tb_par) exp_busy = 514;
`endif
    push_page(pg);
    bif.cpu_addr  = 16'h4014;
    bif.cpu_d_out = pg;
    bif.cpu_we    = 1'b1;
    #1;
    check({tag, "_trig_we"}, 32'(bif.bus_we), 32'd1);
    check({tag, "_trig_addr"}, 32'(bif.bus_addr), 32'h4014);
    check({tag, "_trig_rdy"}, 32'(bif.cpu_rdy), 32'd1);
    tick(1);
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 16'h0100;
    #1;
    check({tag, "_halt_rdy"}, 32'(bif.cpu_rdy), 32'd0);
    check({tag, "_halt_we"}, 32'(bif.bus_we), 32'd0);
    if (poke) begin
      // CPU keeps hammering the DMA register; none of it may matter.
      for (int i = 0; i < 40; i++) begin
        bif.cpu_addr  = 16'h4014;
        bif.cpu_d_out = 8'h77;
        bif.cpu_we    = i[0];
        tick(1);
      end
      bif.cpu_we   = 1'b0;
      bif.cpu_addr = 16'h0100;
    end
    wait_idle(tag, 700);
    check({tag, "_busy_cycles"}, 32'(last_busy), 32'(exp_busy));
    check({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int k;
    rst           = 1'b1;
    bif.cpu_addr  = 16'h1234;
    bif.cpu_d_out = 8'h5A;
    bif.cpu_we    = 1'b1;
    #1;
    check("rst_rdy", 32'(bif.cpu_rdy), 32'd1);
    check("rst_busy", 32'(bif.dma_busy), 32'd0);
    check("rst_addr", 32'(bif.bus_addr), 32'h1234);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("idle_addr", 32'(bif.bus_addr), 32'h1234);
    check("idle_dout", 32'(bif.bus_d_out), 32'h5A);
    check("idle_we", 32'(bif.bus_we), 32'd1);
    check("idle_rdy", 32'(bif.cpu_rdy), 32'd1);
    bif.cpu_we = 1'b0;
    tick(1);

    set_par(1'b1);
    run_dma(8'h02, "pg02_par1", 1'b0);
    set_par(1'b0);
    run_dma(8'h02, "pg02_par0", 1'b0);
    tick(3);
    run_dma(8'hFF, "pgff", 1'b0);
    check("pgff_idle_pass", 32'(bif.bus_addr), 32'h0100);
    tick(2);
    run_dma(8'h03, "pg03_poke", 1'b1);
    tick(2);

    // Abort mid-transfer with reset after 100 OAM writes.
    base = oam_writes;
    push_page(8'h02);
    bif.cpu_addr  = 16'h4014;
    bif.cpu_d_out = 8'h02;
    bif.cpu_we    = 1'b1;
    tick(1);
    bif.cpu_we = 1'b0;
    k = 0;
    while ((oam_writes - base) < 100 && k < 400) begin
      tick(1);
      k++;
    end
    check("abort_reached_100", 32'(oam_writes - base), 32'd100);
    bif.cpu_addr = 16'h0300;
    rst = 1'b1;
    #1;
    check("abort_rdy", 32'(bif.cpu_rdy), 32'd1);
    check("abort_busy", 32'(bif.dma_busy), 32'd0);
    check("abort_we0", 32'(bif.bus_we), 32'd0);
    check("abort_addr", 32'(bif.bus_addr), 32'h0300);
    bif.cpu_we = 1'b1;
    #1;
    check("abort_we1", 32'(bif.bus_we), 32'd1);
    // A DMA-register write while reset is held must lose.
    bif.cpu_addr  = 16'h4014;
    bif.cpu_d_out = 8'h55;
    tick(2);
    exp_q.delete();
    bif.cpu_we   = 1'b0;
    bif.cpu_addr = 16'h0300;
    rst = 1'b0;
    tick(1);
    check("post_rst_rdy", 32'(bif.cpu_rdy), 32'd1);
    base = oam_writes;
    tick(300);
    check("no_writes_after_abort", 32'(oam_writes), 32'(base));
    check("still_idle", 32'(bif.cpu_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
